// File: rtl/timer_dev_if.sv
// Data-side bus port of the countdown timer: word address, write strobe, store data,
// combinational read data and the level interrupt back to the core.
interface timer_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer, one-shot or auto-reload, with a maskable level interrupt.
// Latency: register writes land on the edge; reads are combinational with zero added latency.
// Backpressure: none; every bus access completes in the cycle it is presented.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic ctrl_wr;
  logic preset_wr;

  assign ctrl_wr   = bus.we && (bus.addr == 2'd0);
  assign preset_wr = bus.we && (bus.addr == 2'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'd0;
      ctrl_im   <= 1'b0;
      preset    <= 32'd0;
      count     <= 32'd0;
      irq_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl_en) state <= LOAD;
        end
        LOAD: begin
          count    <= preset;
          irq_flag <= 1'b0;
          state    <= CNT;
        end
        CNT: begin
          if (!ctrl_en) begin
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            // A preset of 0 lands here too, so it expires like a preset of 1.
            count    <= 32'd0;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          if (ctrl_mode == 2'd1) begin
            irq_flag <= 1'b0;
            state    <= LOAD;
          end else begin
            ctrl_en <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Bus writes come last so they override same-edge FSM updates to CTRL and irq_flag.
      if (ctrl_wr) begin
        ctrl_en   <= bus.wdata[0];
        ctrl_mode <= bus.wdata[2:1];
        ctrl_im   <= bus.wdata[3];
        irq_flag  <= 1'b0;
      end
      if (preset_wr) preset <= bus.wdata;
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      2'd0:    bus.rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
      2'd1:    bus.rdata = preset;
      2'd2:    bus.rdata = count;
      default: bus.rdata = 32'd0;
    endcase
  end

  assign bus.irq = irq_flag & ctrl_im;

endmodule

// File: tb/tb_timer_dev.sv
// Directed bench for timer_dev: stimulus pushes expected read data and irq into a scoreboard,
// a negedge monitor pops and compares whenever a check is presented.
module tb_timer_dev;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  timer_dev_if bus ();

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic        chk_vld = 1'b0;
  logic [31:0] exp_rdat_q [$];
  logic        exp_irq_q  [$];
  string       name_q     [$];

  logic [31:0] mon_rdat;
  logic        mon_irq;
  string       mon_name;

  always @(negedge clk) begin
    if (chk_vld) begin
      if (exp_rdat_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_underflow: check presented with no expectation queued");
      end else begin
        mon_rdat = exp_rdat_q.pop_front();
        mon_irq  = exp_irq_q.pop_front();
        mon_name = name_q.pop_front();
        total++;
        if (bus.rdata !== mon_rdat) begin
          bad++;
          $display("FAIL %s rdata: got %h expected %h", mon_name, bus.rdata, mon_rdat);
        end
        total++;
        if (bus.irq !== mon_irq) begin
          bad++;
          $display("FAIL %s irq: got %b expected %b", mon_name, bus.irq, mon_irq);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic check(input logic [1:0] a, input logic [31:0] er, input logic ei, input string nm);
    bus.addr = a;
    exp_rdat_q.push_back(er);
    exp_irq_q.push_back(ei);
    name_q.push_back(nm);
    chk_vld = 1'b1;
    @(negedge clk);
    #1;
    chk_vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ar_cnt [4];
    logic        ar_irq [4];

    reset     = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 2'd0;
    bus.wdata = 32'd0;
    tick();
    tick();
    reset = 1'b1;

    // Reset after some activity
    wr(2'd1, 32'hDEAD_BEEF);
    wr(2'd0, 32'h0000_000B);
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check(2'd0, 32'd0, 1'b0, "reset_ctrl");
    check(2'd1, 32'd0, 1'b0, "reset_preset");
    check(2'd2, 32'd0, 1'b0, "reset_count");
    check(2'd3, 32'd0, 1'b0, "reset_rsvd");
    reset = 1'b1;
    tick();
    check(2'd2, 32'd0, 1'b0, "reset_idle_count");
    tick();
    check(2'd0, 32'd0, 1'b0, "reset_idle_ctrl");

    // One-shot, PRESET=3
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    tick();
    tick();
    check(2'd2, 32'd3, 1'b0, "os_e2");
    tick();
    check(2'd2, 32'd2, 1'b0, "os_e3");
    tick();
    check(2'd2, 32'd1, 1'b0, "os_e4");
    tick();
    check(2'd2, 32'd0, 1'b1, "os_e5_irq");
    tick();
    check(2'd0, 32'h8, 1'b1, "os_e6_en_clr");
    tick();
    check(2'd0, 32'h8, 1'b1, "os_e7_irq_hold");
    wr(2'd0, 32'h8);
    check(2'd0, 32'h8, 1'b0, "os_irq_clr");

    // Auto-reload, PRESET=2: per-cycle COUNT 2,1,0,0 with irq in the INT cycle
    ar_cnt[0] = 32'd2; ar_cnt[1] = 32'd1; ar_cnt[2] = 32'd0; ar_cnt[3] = 32'd0;
    ar_irq[0] = 1'b0;  ar_irq[1] = 1'b0;  ar_irq[2] = 1'b1;  ar_irq[3] = 1'b0;
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      check(2'd2, ar_cnt[i % 4], ar_irq[i % 4], $sformatf("ar_cyc%0d", i));
      tick();
    end
    wr(2'd0, 32'h0);
    tick();
    tick();
    tick();

    // Masked irq, ignored writes
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    tick();
    tick();
    check(2'd2, 32'd1, 1'b0, "mask_cnt1");
    tick();
    check(2'd2, 32'd0, 1'b0, "mask_cnt0_no_irq");
    tick();
    check(2'd0, 32'd0, 1'b0, "mask_en_clr");
    wr(2'd2, 32'h55);
    check(2'd2, 32'd0, 1'b0, "count_wr_ignored");
    wr(2'd3, 32'hFFFF_FFFF);
    check(2'd3, 32'd0, 1'b0, "rsvd_reads_0");
    wr(2'd0, 32'hFFFF_FFF0);
    check(2'd0, 32'd0, 1'b0, "ctrl_upper_ignored");

    // Disable mid-count then restart from the new PRESET
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    tick();
    tick();
    tick();
    tick();
    tick();
    check(2'd2, 32'd7, 1'b0, "dis_cnt7");
    wr(2'd0, 32'h0);
    check(2'd2, 32'd6, 1'b0, "dis_last_dec");
    tick();
    check(2'd2, 32'd6, 1'b0, "dis_frozen");
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h1);
    check(2'd2, 32'd6, 1'b0, "restart_idle");
    tick();
    check(2'd2, 32'd6, 1'b0, "restart_load");
    tick();
    check(2'd2, 32'd4, 1'b0, "restart_from_preset");
    check(2'd1, 32'd4, 1'b0, "preset_readback");
    wr(2'd0, 32'h0);
    tick();
    tick();

    // Reset while counting
    wr(2'd1, 32'd8);
    wr(2'd0, 32'h9);
    tick();
    tick();
    tick();
    tick();
    tick();
    check(2'd2, 32'd5, 1'b0, "rst_mid_cnt5");
    reset = 1'b0;
    tick();
    check(2'd2, 32'd0, 1'b0, "rst_mid_count");
    check(2'd0, 32'd0, 1'b0, "rst_mid_ctrl");
    check(2'd1, 32'd0, 1'b0, "rst_mid_preset");
    reset = 1'b1;
    tick();

    // CTRL write on the INT-entry edge clears the flag it would set
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    tick();
    tick();
    tick();
    wr(2'd0, 32'h8);
    check(2'd0, 32'h8, 1'b0, "coll_int_entry");
    tick();
    check(2'd0, 32'h8, 1'b0, "coll_after_int");
    check(2'd2, 32'd0, 1'b0, "coll_count");

    // CTRL write on the edge where the FSM clears EN: the bus value wins
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    tick();
    tick();
    tick();
    tick();
    check(2'd2, 32'd0, 1'b1, "coll2_int_irq");
    wr(2'd0, 32'h9);
    check(2'd0, 32'h9, 1'b0, "coll2_bus_wins");

    for (int i = 0; i < 10 && exp_rdat_q.size() != 0; i++) @(negedge clk);
    if (exp_rdat_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_rdat_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
